uart_rx_param: RTL and testbench

Parametrised, oversampling UART receiver. It is the next-generation successor to the fixed 8N1 receiver. It supports configurable data width, runtime parity and stop-bit selection, and 3-sample majority voting per bit. It flags framing, parity, break and overrun errors, and delivers each frame through a valid/ready handshake. It sits between the pad synchroniser-free rx pin and any byte consumer, such as a FIFO or CSR block.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: parity encodings, FSM states
// and the per-frame status word. Kept separate so a future transmitter can reuse it.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic brk;
  } frame_status_t;

  // Mode 2'b11 is reserved and behaves as "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

  // ones_odd is the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(input logic [1:0] mode, input logic ones_odd);
    if (mode == PARITY_EVEN) return ones_odd;
    if (mode == PARITY_ODD)  return !ones_odd;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-clock tick every (div+1) clocks. The divisor is
// either the live input or a copy captured with load, selected by hold.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clock_div,
  input  logic                 load,
  input  logic                 hold,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div;

  assign div = hold ? div_q : clock_div;
  // >= rather than == so a live divisor lowered below the count wraps at once
  assign tick = (count >= div);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      div_q <= '0;
    end else begin
      count <= tick ? '0 : count + DIV_WIDTH'(1);
      if (load) div_q <= clock_div;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 3-sample majority voting, runtime parity and
// stop-bit selection, error flags and a one-deep valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clock_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SCW-1:0] SC_S0   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_DEC  = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BIT_LAST = BIW'(DATA_BITS - 1);

  logic                 rx_meta, rx_s;
  rx_state_t            state;
  logic [SCW-1:0]       sc;
  logic [BIW-1:0]       bit_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           pmode_q;
  logic                 stop2_q, stop_idx, pbit, perr, ferr;
  frame_status_t        status_q, status_now;
  logic                 tick, start_det, vote, par_en, commit, fe_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign start_det = (state == ST_IDLE) && tick && !rx_s;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clock     (clock),
    .reset     (reset),
    .clock_div (clock_div),
    .load      (start_det),
    .hold      (state != ST_IDLE),
    .tick      (tick)
  );

  // Third sample is the live rx_s at the decision tick.
  assign vote   = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign par_en = parity_enabled(pmode_q);
  assign fe_now = ferr | ~vote;
  assign commit = (state == ST_STOP) && tick && (sc == SC_DEC) && (!stop2_q || stop_idx);

  always_comb begin
    status_now            = '0;
    status_now.parity_err = perr;
    status_now.frame_err  = fe_now;
    status_now.brk        = fe_now && (shreg == '0) && (!par_en || !pbit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sc         <= '0;
      bit_idx    <= '0;
      samp       <= '0;
      shreg      <= '0;
      pmode_q    <= PARITY_NONE;
      stop2_q    <= 1'b0;
      stop_idx   <= 1'b0;
      pbit       <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      status_q   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      // NOTE: a later non-blocking assignment in this block overrides an earlier default.
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          status_q <= status_now;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end

      if (tick) begin
        if (state != ST_IDLE && state != ST_WAIT_HIGH) begin
          sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
          if (sc == SC_S0) samp[0] <= rx_s;
          if (sc == SC_S1) samp[1] <= rx_s;
        end
        unique case (state)
          ST_IDLE: if (!rx_s) begin
            // The detecting tick is sc=0 of the start bit, so the next tick is 1.
            state    <= ST_START;
            sc       <= SCW'(1);
            pmode_q  <= parity_mode;
            stop2_q  <= stop_bits;
            stop_idx <= 1'b0;
            bit_idx  <= '0;
            pbit     <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
          ST_START: begin
            if (sc == SC_DEC && vote) begin
              state <= ST_IDLE;
            end else if (sc == SC_LAST) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            if (sc == SC_DEC) shreg[bit_idx] <= vote;
            if (sc == SC_LAST) begin
              if (bit_idx == BIT_LAST) state <= par_en ? ST_PARITY : ST_STOP;
              else bit_idx <= bit_idx + BIW'(1);
            end
          end
          ST_PARITY: begin
            if (sc == SC_DEC) begin
              pbit <= vote;
              perr <= parity_error(pmode_q, (^shreg) ^ vote);
            end
            if (sc == SC_LAST) state <= ST_STOP;
          end
          ST_STOP: begin
            // Commit mid-bit on the last stop bit so a back-to-back start is not missed.
            if (sc == SC_DEC) begin
              if (commit) begin
                state <= fe_now ? ST_WAIT_HIGH : ST_IDLE;
                sc    <= '0;
              end else begin
                ferr <= fe_now;
              end
            end else if (sc == SC_LAST) begin
              stop_idx <= 1'b1;
            end
          end
          ST_WAIT_HIGH: if (rx_s) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_parity_err = status_q.parity_err;
  assign rx_frame_err  = status_q.frame_err;
  assign rx_break      = status_q.brk;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised and directed stimulus for uart_rx_param, scored against a frame-level
// model that derives data and error flags from the bits placed on the line.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] clock_div = 16'd3;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop_bits = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          pe;
    logic          fe;
    logic          brk;
  } frame_t;

  frame_t got_q[$];
  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_overrun = 0;

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_WIDTH(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_div     (clock_div),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_break      (rx_break),
    .rx_overrun    (rx_overrun)
  );

  always #5 clock = ~clock;

  // Handshakes complete at the next rising edge; observe them mid-cycle.
  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready)
      got_q.push_back(frame_t'{data: rx_data, pe: rx_parity_err, fe: rx_frame_err, brk: rx_break});
    if (!reset && rx_overrun) n_overrun++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame outcome from the line bits: count ones for parity, any low stop bit is a
  // framing error, and a break is a framing error on an all-zero frame.
  function automatic frame_t model_frame(input logic [DB-1:0] d, input logic [1:0] pm,
                                         input logic s2, input logic p,
                                         input logic st1, input logic st2);
    frame_t f;
    int     ones;
    logic   pen;
    pen   = (pm == 2'd1) || (pm == 2'd2);
    ones  = $countones(d) + (p ? 1 : 0);
    f.data = d;
    f.pe   = (pm == 2'd1) ? (ones % 2 == 1) : (pm == 2'd2) ? (ones % 2 == 0) : 1'b0;
    f.fe   = !st1 || (s2 && !st2);
    f.brk  = f.fe && (d == '0) && (!pen || !p);
    return f;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2,
                            input logic p, input logic st1, input logic st2,
                            input int glitch_bit, input bit expect_it);
    int bc, g, a;
    g  = int'(clock_div) + 1;
    bc = g * OS;
    a  = bc / 2 - 2;
    parity_mode = pm;
    stop_bits   = s2;
    if (expect_it) exp_q.push_back(model_frame(d, pm, s2, p, st1, st2));
    drive_bit(1'b0, bc);
    // Configuration is captured at start detect; scrambling it now must be harmless.
    parity_mode = 2'($urandom);
    stop_bits   = 1'($urandom);
    for (int i = 0; i < DB; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], a);
        drive_bit(~d[i], g);
        drive_bit(d[i], bc - a - g);
      end else begin
        drive_bit(d[i], bc);
      end
    end
    if (pm == 2'd1 || pm == 2'd2) drive_bit(p, bc);
    drive_bit(st1, bc);
    if (s2) drive_bit(st2, bc);
    drive_bit(1'b1, 2 * bc);
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_perr%0d", tag, i), 32'(got_q[i].pe),   32'(exp_q[i].pe));
      check($sformatf("%s_ferr%0d", tag, i), 32'(got_q[i].fe),   32'(exp_q[i].fe));
      check($sformatf("%s_brk%0d",  tag, i), 32'(got_q[i].brk),  32'(exp_q[i].brk));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int bc;
    logic [DB-1:0] rd;
    logic [1:0] rpm;
    logic rs2, rp, rst1, rst2;
    int rg;

    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid",   32'(rx_valid),      32'd0);
    check("rst_data",    32'(rx_data),       32'd0);
    check("rst_perr",    32'(rx_parity_err), 32'd0);
    check("rst_ferr",    32'(rx_frame_err),  32'd0);
    check("rst_brk",     32'(rx_break),      32'd0);
    check("rst_overrun", 32'(rx_overrun),    32'd0);

    // Start bit placed so detection lands on the first possible tick after sync.
    repeat (9) @(posedge clock);
    #1;
    lat = 0;
    fork
      send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      begin
        for (int i = 1; i <= 2000; i++) begin
          @(posedge clock);
          #1;
          if (rx_valid) begin
            lat = i;
            break;
          end
        end
        check("a5_latency_window", 32'(lat >= 600 && lat <= 616), 32'd1);
        @(posedge clock);
        #1;
        check("a5_valid_pulse", 32'(rx_valid), 32'd0);
      end
    join
    compare_frames("a5");

    send_frame(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    send_frame(8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    send_frame(8'h07, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    send_frame(8'h07, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    compare_frames("parity");

    send_frame(8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b1);
    send_frame(8'hE1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    compare_frames("stop2");

    bc = (int'(clock_div) + 1) * OS;
    parity_mode = 2'd0;
    stop_bits   = 1'b0;
    exp_q.push_back(model_frame('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_bit(1'b0, 30 * bc);
    drive_bit(1'b1, 2 * bc);
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    compare_frames("break");

    drive_bit(1'b0, 4 * (int'(clock_div) + 1));
    drive_bit(1'b1, 2 * bc);
    send_frame(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    compare_frames("glitch");

    rx_ready  = 1'b0;
    n_overrun = 0;
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check("ovr_valid", 32'(rx_valid),  32'd1);
    check("ovr_data",  32'(rx_data),   32'h11);
    check("ovr_count", 32'(n_overrun), 32'd1);

    drive_bit(1'b0, 3 * bc);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_valid", 32'(rx_valid),      32'd0);
    check("mid_rst_data",  32'(rx_data),       32'd0);
    check("mid_rst_perr",  32'(rx_parity_err), 32'd0);
    check("mid_rst_ferr",  32'(rx_frame_err),  32'd0);
    check("mid_rst_brk",   32'(rx_break),      32'd0);
    rx = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    rx_ready = 1'b1;
    drive_bit(1'b1, 2 * bc);
    got_q.delete();
    send_frame(8'h96, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    compare_frames("post_rst");

    for (int n = 0; n < 12; n++) begin
      clock_div = DW'($urandom_range(0, 3));
      drive_bit(1'b1, 2 * (int'(clock_div) + 1) * OS);
      rd   = DB'($urandom);
      rpm  = 2'($urandom_range(0, 3));
      rs2  = 1'($urandom);
      rp   = 1'($urandom);
      rst1 = ($urandom_range(0, 3) != 0);
      rst2 = ($urandom_range(0, 3) != 0);
      rg   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
      if (n == 0) rd = '0;
      send_frame(rd, rpm, rs2, rp, rst1, rst2, rg, 1'b1);
    end
    compare_frames("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
